// File: rtl/beatmap_note_scheduler_if.sv
// Byte-stream handshake into the note scheduler and the note event strobe out of it.
interface beatmap_note_scheduler_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       note_valid;
    logic [3:0] note_lanes;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  note_valid,
        input  note_lanes
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output note_valid,
        output note_lanes
    );
endinterface

// File: rtl/beatmap_note_scheduler.sv
// Buffers beatmap bytes in a small FIFO and releases one note event per byte,
// aligned to a beat tick derived from clk.
module beatmap_note_scheduler #(
    parameter int TICK_DIV   = 50,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    beatmap_note_scheduler_if.slave       bus,
    input  logic                          start,
    input  logic                          pause,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underrun,
    output logic                          done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef logic [AW:0]   count_t;
    typedef logic [AW-1:0] ptr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    ptr_t          wr_ptr, rd_ptr;
    logic [CW-1:0] tick_cnt;
    logic [3:0]    wait_cnt;
    logic [3:0]    mask;

    logic       push, pop, fifo_empty, head_is_end;
    logic       active, running, tick, restart, fire;
    logic [7:0] head;

    assign bus.byte_ready = (fifo_count != count_t'(FIFO_DEPTH));
    assign push        = bus.byte_valid && bus.byte_ready;
    assign fifo_empty  = (fifo_count == '0);
    assign head        = mem[rd_ptr];
    assign head_is_end = (head == 8'h00);

    assign active  = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_EMIT);
    assign running = active && !pause;
    assign tick    = running && (tick_cnt == CW'(TICK_DIV - 1));
    assign restart = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign fire    = (state_q == S_WAIT) && tick && (wait_cnt == 4'd0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_is_end ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: if (fire) state_d = S_EMIT;
            S_EMIT: state_d = S_LOAD;
            S_DONE: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the byte storage has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.byte_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            tick_cnt       <= '0;
            wait_cnt       <= '0;
            mask           <= '0;
            underrun       <= 1'b0;
            done           <= 1'b0;
            bus.note_valid <= 1'b0;
            bus.note_lanes <= '0;
        end else begin
            state_q    <= state_d;
            fifo_count <= fifo_count + count_t'(push) - count_t'(pop);
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);

            // Counter only runs while a map is playing; IDLE/DONE hold it at zero so a
            // restart always begins a fresh tick period.
            if (!active) begin
                tick_cnt <= '0;
            end else if (running) begin
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            end

            if (pop && !head_is_end) begin
                wait_cnt <= head[7:4];
                mask     <= head[3:0];
            end else if ((state_q == S_WAIT) && tick && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (restart) begin
                underrun <= 1'b0;
            end else if ((state_q == S_LOAD) && fifo_empty) begin
                underrun <= 1'b1;
            end

            if (restart) begin
                done <= 1'b0;
            end else if (pop && head_is_end) begin
                done <= 1'b1;
            end

            bus.note_valid <= fire;
            bus.note_lanes <= fire ? mask : 4'd0;
        end
    end

endmodule
